// File: rtl/alu_pkg.sv
// Operation encoding shared by the pipelined lookahead ALU and its users.
package alu_pkg;
   localparam int ALU_OP_W = 2;

   typedef enum logic [ALU_OP_W-1:0] {
      ADD  = 2'd0,
      SUB  = 2'd1,
      SLT  = 2'd2,
      SLTU = 2'd3
   } alu_op_e;
endpackage

// File: rtl/cla_group.sv
// One carry-lookahead group: per-bit carries from a group carry-in, plus group G/P.
// Purely combinational; c[i] is the carry into bit i, so c[0] equals cin.
module cla_group #(
   parameter int GROUP = 8
) (
   input  logic [GROUP-1:0] g,
   input  logic [GROUP-1:0] p,
   input  logic             cin,
   output logic [GROUP-1:0] c,
   output logic             pout,
   output logic             gout
);
   logic carry;
   logic gacc;
   logic pacc;

   always_comb begin
      c     = '0;
      carry = cin;
      gacc  = 1'b0;
      pacc  = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
         c[i]  = carry;
         carry = g[i] | (p[i] & carry);
         gacc  = g[i] | (p[i] & gacc);
         pacc  = pacc & p[i];
      end
      pout = pacc;
      gout = gacc;
   end
endmodule

// File: rtl/cla_pipe_alu.sv
// Two-stage add/sub/compare unit on two-level carry lookahead; 2-cycle latency, 1/cycle.
// Stalls propagate back combinationally: in_ready = ~s1_valid | ~out_valid | out_ready.
module cla_pipe_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int GROUP = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_a,
   input  logic [WIDTH-1:0]    in_b,
   input  logic [ALU_OP_W-1:0] in_op,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_result,
   output logic                out_cout,
   output logic                out_ovf,
   output logic                out_zero
);
   localparam int NG = WIDTH / GROUP;

   alu_op_e          op_in;
   logic             adv1, adv2;
   logic             cin0;
   logic [WIDTH-1:0] b_x, g0, p0;
   logic [NG-1:0]    gg0, pg0;
   logic [WIDTH-1:0] c1_unused;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_g, s1_p;
   logic [NG-1:0]    s1_gg, s1_pg;
   logic             s1_cin;
   alu_op_e          s1_op;

   logic [NG:0]      cg;
   logic             acc, term;
   logic [WIDTH-1:0] cvec, sum, res_nx;
   logic [NG-1:0]    gg2_unused, pg2_unused;
   logic             cout_nx, ovf_nx;

   assign adv2     = ~out_valid | out_ready;
   assign adv1     = ~s1_valid | adv2;
   assign in_ready = adv1;

   // Subtraction and both compares are a + ~b + 1.
   assign op_in = alu_op_e'(in_op);
   assign cin0  = (op_in != ADD);
   assign b_x   = cin0 ? ~in_b : in_b;
   assign g0    = in_a & b_x;
   assign p0    = in_a ^ b_x;

   for (genvar k = 0; k < NG; k++) begin : g_s1
      cla_group #(.GROUP(GROUP)) u_grp (
         .g    (g0[k*GROUP +: GROUP]),
         .p    (p0[k*GROUP +: GROUP]),
         .cin  (1'b0),
         .c    (c1_unused[k*GROUP +: GROUP]),
         .pout (pg0[k]),
         .gout (gg0[k])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_g     <= '0;
         s1_p     <= '0;
         s1_gg    <= '0;
         s1_pg    <= '0;
         s1_cin   <= 1'b0;
         s1_op    <= ADD;
      end else if (adv1) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_g   <= g0;
            s1_p   <= p0;
            s1_gg  <= gg0;
            s1_pg  <= pg0;
            s1_cin <= cin0;
            s1_op  <= op_in;
         end
      end
   end

   // Group carries as flat sum-of-products over Gg/Pg, not a group-to-group ripple.
   always_comb begin
      cg   = '0;
      acc  = 1'b0;
      term = 1'b0;
      for (int k = 0; k <= NG; k++) begin
         acc = s1_cin;
         for (int j = 0; j < k; j++) acc = acc & s1_pg[j];
         for (int j = 0; j < k; j++) begin
            term = s1_gg[j];
            for (int m = j + 1; m < k; m++) term = term & s1_pg[m];
            acc = acc | term;
         end
         cg[k] = acc;
      end
   end

   for (genvar k = 0; k < NG; k++) begin : g_s2
      cla_group #(.GROUP(GROUP)) u_grp (
         .g    (s1_g[k*GROUP +: GROUP]),
         .p    (s1_p[k*GROUP +: GROUP]),
         .cin  (cg[k]),
         .c    (cvec[k*GROUP +: GROUP]),
         .pout (pg2_unused[k]),
         .gout (gg2_unused[k])
      );
   end

   assign sum     = s1_p ^ cvec;
   assign cout_nx = cg[NG];
   assign ovf_nx  = cvec[WIDTH-1] ^ cout_nx;

   always_comb begin
      case (s1_op)
         SLT:     res_nx = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_nx};
         SLTU:    res_nx = {{(WIDTH-1){1'b0}}, ~cout_nx};
         default: res_nx = sum;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_cout   <= 1'b0;
         out_ovf    <= 1'b0;
         out_zero   <= 1'b0;
      end else if (adv2) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_result <= res_nx;
            out_cout   <= cout_nx;
            out_ovf    <= ovf_nx;
            out_zero   <= ~|res_nx;
         end
      end
   end
endmodule

// File: tb/tb_cla_pipe_alu.sv
// Scoreboard bench: directed 32/8 vectors with hand-computed results, plus 16/4 and 64/8 streams vs a reference model.
module tb_cla_pipe_alu;
   import alu_pkg::*;

   typedef struct packed {
      logic [63:0] res;
      logic        co;
      logic        ov;
      logic        z;
   } res_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   logic        in_valid, in_ready, out_valid, out_ready, out_cout, out_ovf, out_zero;
   logic [31:0] in_a, in_b, out_result;
   logic [1:0]  in_op;

   logic        rv, rrdy, rop_rdy16, rop_rdy64;
   logic [1:0]  rop;
   logic [15:0] a16, b16, res16;
   logic [63:0] a64, b64, res64;
   logic        vo16, co16, of16, z16, vo64, co64, of64, z64;

   res_t q32[$];
   res_t q16[$];
   res_t q64[$];

   cla_pipe_alu #(.WIDTH(32), .GROUP(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_cout(out_cout),
      .out_ovf(out_ovf), .out_zero(out_zero));

   cla_pipe_alu #(.WIDTH(16), .GROUP(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(rv), .in_ready(rop_rdy16),
      .in_a(a16), .in_b(b16), .in_op(rop), .out_valid(vo16),
      .out_ready(rrdy), .out_result(res16), .out_cout(co16),
      .out_ovf(of16), .out_zero(z16));

   cla_pipe_alu #(.WIDTH(64), .GROUP(8)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(rv), .in_ready(rop_rdy64),
      .in_a(a64), .in_b(b64), .in_op(rop), .out_valid(vo64),
      .out_ready(rrdy), .out_result(res64), .out_cout(co64),
      .out_ovf(of64), .out_zero(z64));

   function automatic res_t mk(input logic [31:0] r, input logic c, input logic o, input logic z);
      res_t t;
      t.res = {32'b0, r};
      t.co  = c;
      t.ov  = o;
      t.z   = z;
      return t;
   endfunction

   // Wide-integer reference: w-bit result, carry out of bit w-1, carry into bit w-1.
   function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                  input logic [1:0] op, input int w);
      logic [64:0] mask, full, low;
      logic [63:0] bb, m1, am;
      logic        cin, co, ci, ov;
      res_t        t;
      mask = (65'd1 << w) - 65'd1;
      m1   = (64'd1 << (w - 1)) - 64'd1;
      cin  = (op != 2'd0);
      am   = a & mask[63:0];
      bb   = (cin ? ~b : b) & mask[63:0];
      full = {1'b0, am} + {1'b0, bb} + {64'b0, cin};
      low  = {1'b0, am & m1} + {1'b0, bb & m1} + {64'b0, cin};
      co   = full[w];
      ci   = low[w-1];
      ov   = ci ^ co;
      case (op)
         2'd2:    t.res = {63'b0, full[w-1] ^ ov};
         2'd3:    t.res = {63'b0, ~co};
         default: t.res = full[63:0] & mask[63:0];
      endcase
      t.co = co;
      t.ov = ov;
      t.z  = (t.res == 64'd0);
      return t;
   endfunction

   task automatic check(input string name, input logic ok, input res_t act, input res_t exp);
      total++;
      if (ok) passed++;
      else $display("FAIL %s: got res=%h co=%b ov=%b z=%b, expected res=%h co=%b ov=%b z=%b",
                    name, act.res, act.co, act.ov, act.z, exp.res, exp.co, exp.ov, exp.z);
   endtask

   task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin : mon32
      res_t act, e;
      if (rst_n && out_valid && out_ready) begin
         act = mk(out_result, out_cout, out_ovf, out_zero);
         if (q32.size() == 0) check("spurious_out32", 1'b0, act, '0);
         else begin
            e = q32.pop_front();
            check("res32", act == e, act, e);
         end
      end
   end

   always @(negedge clk) begin : mon16
      res_t act, e;
      if (rst_n && vo16) begin
         act.res = {48'b0, res16}; act.co = co16; act.ov = of16; act.z = z16;
         if (q16.size() == 0) check("spurious_out16", 1'b0, act, '0);
         else begin
            e = q16.pop_front();
            check("res16", act == e, act, e);
         end
      end
   end

   always @(negedge clk) begin : mon64
      res_t act, e;
      if (rst_n && vo64) begin
         act.res = res64; act.co = co64; act.ov = of64; act.z = z64;
         if (q64.size() == 0) check("spurious_out64", 1'b0, act, '0);
         else begin
            e = q64.pop_front();
            check("res64", act == e, act, e);
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input bit push, input res_t e);
      int n;
      n = 0;
      in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) check1("in_ready_timeout", {63'b0, in_ready}, 64'd1);
      if (push) q32.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [35:0] snap;
      bit          saw_full;
      int          spur;
      in_valid = 0; in_a = 0; in_b = 0; in_op = 0; out_ready = 1;
      rv = 0; rrdy = 1; rop = 0; a16 = 0; b16 = 0; a64 = 0; b64 = 0;
      #1 rst_n = 1'b0;
      #11;
      check1("reset_state", {31'b0, out_valid, out_result, out_cout, out_ovf, out_zero}, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Latency: accepted at edge E, visible after E+1
      send(32'h0000_00FF, 32'h0000_0001, ADD, 1, mk(32'h0000_0100, 0, 0, 0));
      @(negedge clk) check1("latency_c1_valid", {63'b0, out_valid}, 64'd0);
      @(negedge clk) check1("latency_c2_valid", {63'b0, out_valid}, 64'd1);
      @(posedge clk);
      #1;

      send(32'hFFFF_FFFF, 32'h0000_0001, ADD,  1, mk(32'h0000_0000, 1, 0, 1));
      send(32'h8000_0000, 32'h0000_0001, SUB,  1, mk(32'h7FFF_FFFF, 1, 1, 0));
      send(32'hFFFF_FFFF, 32'h0000_0001, SLT,  1, mk(32'h0000_0001, 1, 0, 0));
      send(32'hFFFF_FFFF, 32'h0000_0001, SLTU, 1, mk(32'h0000_0000, 1, 0, 1));
      send(32'h7FFF_FFFF, 32'h8000_0000, SLT,  1, mk(32'h0000_0000, 0, 1, 1));
      send(32'h0000_0005, 32'h0000_0005, SUB,  1, mk(32'h0000_0000, 1, 0, 1));
      send(32'h7FFF_FFFF, 32'h0000_0001, ADD,  1, mk(32'h8000_0000, 0, 1, 0));
      send(32'h0000_0001, 32'h0000_0002, SLTU, 1, mk(32'h0000_0001, 0, 0, 0));
      send(32'h0000_0003, 32'h0000_0005, SUB,  1, mk(32'hFFFF_FFFE, 0, 0, 0));
      repeat (4) @(posedge clk);
      #1 check1("drain_directed", q32.size(), 64'd0);

      // Backpressure: out_ready low while the stream is in flight
      fork
         begin
            send(32'h0000_0001, 32'h0000_0002, ADD, 1, mk(32'h0000_0003, 0, 0, 0));
            send(32'h0000_000A, 32'h0000_0003, SUB, 1, mk(32'h0000_0007, 1, 0, 0));
            send(32'h0F0F_0F0F, 32'hF0F0_F0F0, ADD, 1, mk(32'hFFFF_FFFF, 0, 0, 0));
            send(32'hFFFF_FFFE, 32'hFFFF_FFFF, SLT, 1, mk(32'h0000_0001, 0, 0, 0));
         end
         begin
            repeat (2) @(posedge clk);
            #2 out_ready = 1'b0;
            @(negedge clk);
            snap = {out_valid, out_result, out_cout, out_ovf, out_zero};
            check1("stall_out_valid", {63'b0, out_valid}, 64'd1);
            saw_full = 0;
            repeat (3) begin
               @(negedge clk);
               check1("stall_hold", {28'b0, out_valid, out_result, out_cout, out_ovf, out_zero},
                      {28'b0, snap});
               if (!in_ready) saw_full = 1;
            end
            check1("stall_in_ready_low", {63'b0, saw_full}, 64'd1);
            @(posedge clk);
            #2 out_ready = 1'b1;
         end
      join
      repeat (5) @(posedge clk);
      #1 check1("drain_backpressure", q32.size(), 64'd0);

      // Reset with two ops in flight
      send(32'h0000_0011, 32'h0000_0022, ADD, 0, '0);
      send(32'h0000_0033, 32'h0000_0044, ADD, 0, '0);
      #1 rst_n = 1'b0;
      #1;
      check1("midrst_out_valid", {63'b0, out_valid}, 64'd0);
      check1("midrst_out_result", {32'b0, out_result}, 64'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      spur = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) spur++;
      end
      check1("no_stale_after_reset", spur, 64'd0);
      @(posedge clk);
      #1;
      send(32'h1234_5678, 32'h1111_1111, ADD, 1, mk(32'h2345_6789, 0, 0, 0));
      repeat (4) @(posedge clk);
      #1 check1("drain_post_reset", q32.size(), 64'd0);

      // Parameter sweep against the reference model
      for (int i = 0; i < 1000; i++) begin
         rop = 2'($urandom_range(0, 3));
         a16 = 16'($urandom);
         b16 = 16'($urandom);
         a64 = {$urandom, $urandom};
         b64 = {$urandom, $urandom};
         if (i % 16 == 0) begin
            a16 = 16'hFFFF;
            b16 = (i % 32 == 0) ? 16'h0001 : 16'h8000;
            a64 = 64'hFFFF_FFFF_FFFF_FFFF;
            b64 = (i % 32 == 0) ? 64'd1 : 64'h8000_0000_0000_0000;
         end
         rv = 1'b1;
         q16.push_back(model({48'b0, a16}, {48'b0, b16}, rop, 16));
         q64.push_back(model(a64, b64, rop, 64));
         @(posedge clk);
         #1;
      end
      rv = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check1("drain_sweep16", q16.size(), 64'd0);
      check1("drain_sweep64", q64.size(), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/cla_pipe_alu.md
Name: cla_pipe_alu

Overview:
- Parametrised, two-stage pipelined add/sub/compare unit built from group carry-lookahead cells.
- Generalises the fixed 8-bit lookahead unit: width and group size are configurable, group carries come from a second lookahead level, and ADD/SUB/SLT/SLTU modes are supported.
- Sits between operand issue and writeback in the ALU datapath, with a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of GROUP and at least 2*GROUP.
- GROUP, 8, bits per lookahead group; NG = WIDTH/GROUP groups.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and op are valid this cycle
- in_ready  output  1  block accepts input this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  2  operation: ADD=0, SUB=1, SLT=2, SLTU=3
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_result  output  WIDTH  sum/difference, or zero-extended compare bit
- out_cout  output  1  carry out of MSB (SUB/SLT/SLTU: 1 = no borrow)
- out_ovf  output  1  signed overflow of the add/sub
- out_zero  output  1  out_result == 0

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_cout=0, out_ovf=0, out_zero=0; pipeline registers cleared. Reset mid-operation discards all in-flight results; no output appears after release until new input is accepted.
- Operand prep (comb, before stage 1): b' = (op==ADD) ? in_b : ~in_b; cin = (op!=ADD).
- Stage 1 (registered on accept): per-bit g=a&b', p=a^b' (propagate uses XOR so it doubles as the sum half); per-group Gg/Pg via cla_group with cin=0; register a_msb, b'_msb, p, g, Gg, Pg, cin, op.
- Stage 2 (registered on advance): group carries c[k] = Gg[k-1] | Pg[k-1]&c[k-1] with c[0]=cin, flattened as two-level lookahead; intra-group carries recomputed via cla_group with the group cin; sum = p ^ carry_in_vector.
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB ^ carry out of MSB.
  - SLT result = {0, sum[MSB]^ovf}; SLTU result = {0, ~cout}; ADD/SUB result = sum.
  - zero is computed on the final result. For SLT/SLTU, cout and ovf still report the subtraction.
- Latency: exactly 2 cycles from accepted input to out_valid when not stalled; throughput 1 per cycle.
- Handshake:
  - Accept when in_valid & in_ready. Result transfers when out_valid & out_ready.
  - adv2 = ~s2_valid | out_ready; adv1 = ~s1_valid | adv2; in_ready = adv1 (combinational from out_ready, no skid buffer).
  - On stall (out_valid & ~out_ready), out_* and the stage-1 contents hold stable; a full pipeline holds 2 entries.
  - Simultaneous accept and output transfer in the same cycle is legal and loses no bubble.
  - in_valid while in_ready=0: input is not captured; the source must hold it.
- Arithmetic: all modular in WIDTH bits. Wrap-around (e.g. all-ones + 1) yields result 0, cout=1, zero=1.
- out_valid may not depend combinationally on in_valid.

Decomposition:
- Shared package alu_pkg: op encoding typedef alu_op_e (ADD, SUB, SLT, SLTU) and width constant ALU_OP_W=2.
- Sub-module cla_group (parametric GROUP): combinational inputs g, p, cin; outputs per-bit carries, Pout, Gout. Instantiated NG times in stage 1 (cin=0, Gg/Pg only) and NG times in stage 2 (true group cin).
- Top: operand prep, two register stages, group-level lookahead, result mux, handshake.

Test Plan:
- ADD, WIDTH=32, GROUP=8: 0x0000_00FF + 0x0000_0001 -> result 0x0000_0100, cout=0, ovf=0, zero=0, out_valid exactly 2 cycles after accept.
- Full-width ripple: ADD 0xFFFF_FFFF + 0x0000_0001 -> result 0, cout=1, zero=1; SUB 0x8000_0000 - 1 -> result 0x7FFF_FFFF, ovf=1, cout=1.
- Compare: SLT 0xFFFF_FFFF vs 0x0000_0001 -> result 1; SLTU with the same operands -> result 0; SLT 0x7FFF_FFFF vs 0x8000_0000 -> result 0 (ovf=1 path).
- Backpressure: stream 4 ops back-to-back with out_ready low from cycle 2 to cycle 5 -> in_ready drops once 2 entries are held, out_* stable during the stall, all 4 results delivered in order with no drop or duplicate.
- Reset mid-flight: accept 2 ops, assert rst_n=0 asynchronously between edges -> out_valid=0 immediately; after release, no stale result appears.
- Parameter sweep WIDTH=16/GROUP=4 and WIDTH=64/GROUP=8: 1000 random ops compared against a behavioural reference model -> all fields match.
